// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the five-stage pipeline: register enables, PC enable and half-cycle flush pulses.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined; otherwise the counter ports read 0.
module hazard_control_unit (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_dREN,
    input  logic [4:0]  ex_wsel,
    input  logic        ex_redirect,
    input  logic        wb_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        halt,
    output logic [31:0] stall_cycles,
    output logic [31:0] bubble_count,
    output logic [31:0] flush_count
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t state;
    logic   stall;
    logic   lu;
    logic   req_ifid;
    logic   req_idex;
    logic   ifid_set_p1, idex_set_p1;
    logic   ifid_clr_p1, idex_clr_p1;

    assign stall = !ihit || ((mem_dREN || mem_dWEN) && !dhit);
    assign lu    = ex_dREN && (ex_wsel != 5'd0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));

    // Priority: pending halt, then memory stall, then redirect, then load-use.
    always_comb begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        req_ifid = 1'b0;
        req_idex = 1'b0;
        if (!nRST && state == RUN && !wb_halt && !stall) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (ex_redirect) begin
                req_ifid = 1'b1;
                req_idex = 1'b1;
            end else if (lu) begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                req_idex = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state <= RUN;
            halt  <= 1'b0;
        end else begin
            case (state)
                RUN: if (wb_halt) begin
                    state <= HALTED;
                    halt  <= 1'b1;
                end
                HALTED: begin
                    state <= HALTED;
                    halt  <= 1'b1;
                end
                default: begin
                    state <= RUN;
                    halt  <= 1'b0;
                end
            endcase
        end
    end

    // Toggle pair: the rising-edge flop flips on a request, the falling-edge flop catches up,
    // so the XOR is high for exactly the CLK-high phase, even on back-to-back requests.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            ifid_set_p1 <= 1'b0;
            idex_set_p1 <= 1'b0;
        end else begin
            ifid_set_p1 <= ifid_set_p1 ^ req_ifid;
            idex_set_p1 <= idex_set_p1 ^ req_idex;
        end
    end

    always_ff @(negedge CLK or posedge nRST) begin
        if (nRST) begin
            ifid_clr_p1 <= 1'b0;
            idex_clr_p1 <= 1'b0;
        end else begin
            ifid_clr_p1 <= ifid_set_p1;
            idex_clr_p1 <= idex_set_p1;
        end
    end

    assign ifid_flush  = ifid_set_p1 ^ ifid_clr_p1;
    assign idex_flush  = idex_set_p1 ^ idex_clr_p1;
    assign exmem_flush = 1'b0;
    assign memwb_flush = 1'b0;

`ifdef HAZARD_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            stall_cycles <= 32'd0;
            bubble_count <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (state == RUN && stall)
                stall_cycles <= sat_inc(stall_cycles);
            // A lone ID/EX request is a load-use bubble; a paired request is a redirect.
            if (req_idex && !req_ifid)
                bubble_count <= sat_inc(bubble_count);
            if (req_ifid)
                flush_count <= sat_inc(flush_count);
        end
    end
`else
    assign stall_cycles = 32'd0;
    assign bubble_count = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed cases followed by random episodes checked
// against an event-level reference model (counters checked when HAZARD_PERF_CNT_EN is defined).
module tb_hazard_control_unit;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        ihit, dhit, mem_dREN, mem_dWEN;
    logic [4:0]  id_rs, id_rt, ex_wsel;
    logic        ex_dREN, ex_redirect, wb_halt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        halt;
    logic [31:0] stall_cycles, bubble_count, flush_count;

    hazard_control_unit dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .id_rs(id_rs), .id_rt(id_rt),
        .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .ex_redirect(ex_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halt(halt),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count), .flush_count(flush_count)
    );

    always #5 CLK = ~CLK;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int EV_HALTED = 0, EV_HPEND = 1, EV_STALL = 2, EV_REDIR = 3, EV_LU = 4, EV_NORM = 5;

    int n_cmp = 0;
    int n_err = 0;

    bit          m_halted;
    logic [31:0] m_stall, m_bub, m_fl;
    logic [1:0]  m_pulse;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic bit mem_wait();
        return !ihit || ((mem_dREN || mem_dWEN) && !dhit);
    endfunction

    function automatic bit load_use();
        return ex_dREN && (ex_wsel != 0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));
    endfunction

    function automatic int classify();
        if (m_halted)     return EV_HALTED;
        if (wb_halt)      return EV_HPEND;
        if (mem_wait())   return EV_STALL;
        if (ex_redirect)  return EV_REDIR;
        if (load_use())   return EV_LU;
        return EV_NORM;
    endfunction

    // {pc, ifid, idex, exmem, memwb}
    function automatic logic [4:0] en_of(input int ev);
        case (ev)
            EV_REDIR, EV_NORM: return 5'b11111;
            EV_LU:             return 5'b00111;
            default:           return 5'b00000;
        endcase
    endfunction

    task automatic model_reset();
        m_halted = 0;
        m_stall  = 0;
        m_bub    = 0;
        m_fl     = 0;
        m_pulse  = 0;
    endtask

    task automatic idle_inputs();
        ihit = 1; dhit = 1; mem_dREN = 0; mem_dWEN = 0;
        id_rs = 0; id_rt = 0; ex_dREN = 0; ex_wsel = 0;
        ex_redirect = 0; wb_halt = 0;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, ".stall_cycles"}, stall_cycles, PERF ? m_stall : 32'd0);
        chk({tag, ".bubble_count"}, bubble_count, PERF ? m_bub : 32'd0);
        chk({tag, ".flush_count"},  flush_count,  PERF ? m_fl : 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".enables"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'd0);
        chk({tag, ".flushes"}, 32'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 32'd0);
        chk({tag, ".halt"}, 32'(halt), 32'd0);
        chk({tag, ".stall_cycles"}, stall_cycles, 32'd0);
        chk({tag, ".bubble_count"}, bubble_count, 32'd0);
        chk({tag, ".flush_count"},  flush_count,  32'd0);
    endtask

    // Entered and left in the CLK-low phase with this cycle's inputs already applied.
    task automatic cycle(input string tag);
        int ev;
        bit s;
        #1;
        ev = classify();
        s  = mem_wait();
        chk({tag, ".enables"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(en_of(ev)));
        chk({tag, ".halt"}, 32'(halt), 32'(m_halted));
        chk_counters(tag);
        @(posedge CLK);
        if (!m_halted && s) m_stall = sat1(m_stall);
        if (ev == EV_LU)    m_bub = sat1(m_bub);
        if (ev == EV_REDIR) m_fl = sat1(m_fl);
        if (ev == EV_HPEND) m_halted = 1;
        m_pulse = {ev == EV_REDIR, (ev == EV_REDIR) || (ev == EV_LU)};
        #1;
        chk({tag, ".flush_high"}, 32'({ifid_flush, idex_flush, exmem_flush, memwb_flush}),
            32'({m_pulse, 2'b00}));
        chk({tag, ".halt_after"}, 32'(halt), 32'(m_halted));
        @(negedge CLK);
        #1;
        chk({tag, ".flush_low"}, 32'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 32'd0);
    endtask

    task automatic reset_now(input string tag);
        #1 nRST = 1;
        #1 chk_all_zero(tag);
        model_reset();
        @(negedge CLK);
        #1;
        chk_all_zero({tag, ".held"});
        nRST = 0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        @(negedge CLK);
        #1 chk_all_zero("reset0");
        nRST = 0;
        cycle("release");

        // Load-use on rs, then the bubble leaves EX without a load
        ex_dREN = 1; ex_wsel = 5; id_rs = 5;
        cycle("loaduse");
        chk("loaduse.bubble_count", bubble_count, PERF ? 32'd1 : 32'd0);
        idle_inputs();
        cycle("after_lu");

        ex_dREN = 1; ex_wsel = 0; id_rt = 0;
        cycle("zero_reg");
        idle_inputs();

        // Redirect outranks load-use
        ex_redirect = 1; ex_dREN = 1; ex_wsel = 7; id_rt = 7;
        cycle("redir_lu");
        idle_inputs();
        cycle("after_redir");

        // Stall defers the redirect for three cycles
        reset_now("rst_prio");
        ex_redirect = 1; ex_dREN = 1; ex_wsel = 3; id_rs = 3; mem_dREN = 1; dhit = 0;
        for (int i = 0; i < 3; i++) cycle("stall_redir");
        dhit = 1;
        cycle("stall_release");
        chk("prio.stall_cycles", stall_cycles, PERF ? 32'd3 : 32'd0);
        idle_inputs();
        cycle("after_stall");

        // Reset asserted while a flush pulse is high truncates it
        ex_redirect = 1;
        #1;
        @(posedge CLK);
        #1 chk("pulse_pre_rst", 32'(ifid_flush), 32'd1);
        #1 nRST = 1;
        #1 chk_all_zero("rst_mid_pulse");
        model_reset();
        @(negedge CLK);
        #1 nRST = 0;
        idle_inputs();
        cycle("post_rst");

        // Halt is sticky over later redirects
        wb_halt = 1; ex_redirect = 1;
        cycle("halt_req");
        wb_halt = 0;
        for (int i = 0; i < 4; i++) begin
            ex_redirect = i[0];
            cycle("halted");
        end
        reset_now("rst_halt");
        cycle("post_halt");

        // Back-to-back redirects give two separate pulses
        ex_redirect = 1;
        cycle("redir1");
        cycle("redir2");
        chk("redir.flush_count", flush_count, PERF ? 32'd2 : 32'd0);
        idle_inputs();
        cycle("redir_done");

        for (int ep = 0; ep < 4; ep++) begin
            reset_now("rst_rand");
            for (int i = 0; i < 250; i++) begin
                ihit        = ($urandom_range(0, 5) != 0);
                dhit        = ($urandom_range(0, 3) != 0);
                mem_dREN    = $urandom_range(0, 1);
                mem_dWEN    = ($urandom_range(0, 4) == 0);
                ex_dREN     = $urandom_range(0, 1);
                ex_wsel     = 5'($urandom_range(0, 3));
                id_rs       = 5'($urandom_range(0, 3));
                id_rt       = 5'($urandom_range(0, 3));
                ex_redirect = ($urandom_range(0, 4) == 0);
                wb_halt     = ($urandom_range(0, 149) == 0);
                cycle("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
